// File: rtl/soc_pkg.sv
// soc_pkg: shared RV32I opcode/funct constants, ALU op enum and ALU helpers
package soc_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // funct7 that selects SUB over ADD and SRA over SRL
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

endpackage

// File: rtl/soc_if.sv
// soc_if: instruction fetch bus between core (master) and ROM (slave)
interface soc_if;
    logic [31:0] addr;
    logic [31:0] instr;
    modport master (output addr, input instr);
    modport slave  (input addr, output instr);
endinterface

// File: rtl/soc_regs.sv
// regs: 32x32 register file, two combinational reads, one clocked write
module regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [32];

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    // Whole file clears asynchronously; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/soc_riscv.sv
// riscv: single-cycle RV32I core (decode, immediates, ALU, next-PC)
module riscv
    import soc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    soc_if.master bus
);
    logic [31:0] pc, pc4, next_pc, instr, rs1v, rs2v, wd;
    logic [31:0] imm_i, imm_u, imm_b, imm_j;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt, we, taken;

    assign bus.addr = pc;
    assign instr    = bus.instr;
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign pc4      = pc + 32'd4;
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // Immediate ADDI has no SUB form, so the alternate encoding only matters for REG ops and shifts
    assign alt      = instr[31:25] == F7_ALT && (opcode == OP_REG || f3 == F3_SR);

    regs regs_inst (
        .clk(clk), .rst(rst), .we(we), .waddr(rd), .wdata(wd),
        .raddr1(rs1), .raddr2(rs2), .rdata1(rs1v), .rdata2(rs2v)
    );

    // Branch condition selected by funct3; undefined encodings never branch
    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = rs1v == rs2v;
            F3_BNE:  taken = rs1v != rs2v;
            F3_BLT:  taken = $signed(rs1v) < $signed(rs2v);
            F3_BGE:  taken = $signed(rs1v) >= $signed(rs2v);
            F3_BLTU: taken = rs1v < rs2v;
            F3_BGEU: taken = rs1v >= rs2v;
            default: taken = 1'b0;
        endcase
    end

    // Decode: writeback value, write enable and next PC; anything unlisted is a NOP
    always_comb begin
        we      = 1'b0;
        wd      = pc4;
        next_pc = pc4;
        case (opcode)
            OP_LUI:    begin we = 1'b1; wd = imm_u; end
            OP_AUIPC:  begin we = 1'b1; wd = pc + imm_u; end
            OP_JAL:    begin we = 1'b1; next_pc = pc + imm_j; end
            OP_JALR:   begin we = 1'b1; next_pc = (rs1v + imm_i) & ~32'd1; end
            OP_BRANCH: next_pc = taken ? pc + imm_b : pc4;
            OP_IMM:    begin we = 1'b1; wd = alu_eval(alu_sel(f3, alt), rs1v, imm_i); end
            OP_REG:    begin we = 1'b1; wd = alu_eval(alu_sel(f3, alt), rs1v, rs2v); end
            default:   we = 1'b0;
        endcase
    end

    // Program counter, forced to RESET_PC asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= next_pc;
    end
endmodule

// File: rtl/soc_rom.sv
// rom: word-addressed instruction ROM, loaded externally, combinational read
module rom #(
    parameter int ROM_DEPTH = 4096
) (
    soc_if.slave bus
);
    localparam int AW = $clog2(ROM_DEPTH);

    logic [31:0] rom_mem [ROM_DEPTH];
    logic        unused_addr;

    assign bus.instr   = rom_mem[bus.addr[AW+1:2]];
    assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
endmodule

// File: rtl/soc.sv
// soc: RV32I core plus instruction ROM joined by the fetch bus
module soc #(
    parameter int          ROM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    soc_if bus ();

    riscv #(.RESET_PC(RESET_PC)) riscv_inst (.clk(clk), .rst(rst), .bus(bus.master));
    rom #(.ROM_DEPTH(ROM_DEPTH)) rom_inst (.bus(bus.slave));
endmodule

// File: tb/tb_soc.sv
// tb_soc: directed and random-program checks of soc against an instruction-level model
module tb_soc;
    localparam int DEPTH = 4096;
    localparam int AW = $clog2(DEPTH);
    localparam int OPI = 'h13, OPR = 'h33, LUI = 'h37, AUIPC = 'h17, JAL = 'h6F, JALR = 'h67;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] prog [DEPTH];
    logic [31:0] mregs [32];
    logic [31:0] m_pc;
    int m_rd;

    soc_if probe ();
    soc #(.ROM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));
    assign probe.addr  = dut.riscv_inst.pc;
    assign probe.instr = dut.riscv_inst.instr;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xr(input int i);
        return dut.riscv_inst.regs_inst.regs[i[4:0]];
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int f3, input int rs1, input int imm);
        logic [31:0] o = op, d = rd, f = f3, s = rs1, m = imm;
        return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] g = f7, t = rs2, s = rs1, f = f3, d = rd;
        return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(input int op, input int rd, input logic [31:0] imm);
        logic [31:0] o = op, d = rd;
        return {imm[31:12], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] f = f3, s = rs1, t = rs2, v = imm;
        return {v[12], v[10:5], t[4:0], s[4:0], f[2:0], v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int rd, input int imm);
        logic [31:0] d = rd, v = imm;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6F};
    endfunction

    task automatic put(input int i, input logic [31:0] w);
        prog[i] = w;
        dut.rom_inst.rom_mem[i] = w;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) put(i, 32'h0);
    endtask

    task automatic start();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        m_pc = 32'h0;
        m_rd = 0;
        rst = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Instruction-level reference: RV32I semantics straight from the ISA rules
    task automatic model_step();
        logic [31:0] ins, a, b, y, res, nxt, ii, iu, ib, ij;
        logic [4:0] rd, sh;
        logic [2:0] f3;
        logic wr, tk;
        ins = prog[m_pc[AW+1:2]];
        rd  = ins[11:7];
        f3  = ins[14:12];
        a   = mregs[ins[19:15]];
        b   = mregs[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        iu  = {ins[31:12], 12'b0};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        wr  = 1'b1;
        tk  = 1'b0;
        res = m_pc + 32'd4;
        nxt = m_pc + 32'd4;
        case (ins[6:0])
            7'h37: res = iu;
            7'h17: res = m_pc + iu;
            7'h6F: nxt = m_pc + ij;
            7'h67: nxt = (a + ii) & ~32'd1;
            7'h63: begin
                wr = 1'b0;
                case (f3)
                    3'd0: tk = a == b;
                    3'd1: tk = a != b;
                    3'd4: tk = $signed(a) < $signed(b);
                    3'd5: tk = $signed(a) >= $signed(b);
                    3'd6: tk = a < b;
                    3'd7: tk = a >= b;
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + ib;
            end
            7'h13, 7'h33: begin
                y  = ins[5] ? b : ii;
                sh = y[4:0];
                case (f3)
                    3'd0: res = (ins[5] && ins[30]) ? a - y : a + y;
                    3'd1: res = a << sh;
                    3'd2: res = {31'b0, $signed(a) < $signed(y)};
                    3'd3: res = {31'b0, a < y};
                    3'd4: res = a ^ y;
                    3'd5: if (ins[30]) res = $signed(a) >>> sh; else res = a >> sh;
                    3'd6: res = a | y;
                    default: res = a & y;
                endcase
            end
            default: wr = 1'b0;
        endcase
        if (wr && rd != 5'd0) mregs[rd] = res;
        m_rd = int'(rd);
        m_pc = nxt;
    endtask

    // Random legal instruction at word k; control transfers stay inside the 64-word program
    function automatic logic [31:0] rand_instr(input int k);
        int sel = $urandom_range(0, 9);
        int rd = $urandom_range(0, 7);
        int rs1 = $urandom_range(0, 7);
        int rs2 = $urandom_range(0, 7);
        int f3 = $urandom_range(0, 7);
        int t = $urandom_range(0, 63);
        int imm;
        int bt [6] = '{0, 1, 4, 5, 6, 7};
        int nops [4] = '{'h03, 'h23, 'h0F, 'h73};
        logic [31:0] v, o;
        case (sel)
            0, 1, 2: begin
                if (f3 == 1) imm = $urandom_range(0, 31);
                else if (f3 == 5) imm = $urandom_range(0, 31) + ($urandom_range(0, 1) ? 1024 : 0);
                else imm = $urandom_range(0, 4095);
                return enc_i(OPI, rd, f3, rs1, imm);
            end
            3, 4: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
            5: return enc_u($urandom_range(0, 1) ? LUI : AUIPC, rd, $urandom);
            6: return enc_b(bt[$urandom_range(0, 5)], rs1, rs2, (t - k) * 4);
            7: return enc_j(rd, (t - k) * 4);
            8: return enc_i(JALR, rd, 0, 0, t * 4 + $urandom_range(0, 1));
            default: begin
                v = $urandom;
                o = nops[$urandom_range(0, 3)];
                v[6:0] = o[6:0];
                return v;
            end
        endcase
    endfunction

    task automatic run_random(input int cycles);
        clear_rom();
        for (int k = 0; k < 64; k++) put(k, rand_instr(k));
        start();
        for (int c = 0; c < cycles; c++) begin
            step();
            model_step();
            check("rnd_pc", probe.addr, m_pc);
            check($sformatf("rnd_x%0d", m_rd), xr(m_rd), mregs[m_rd]);
            check("rnd_fetch", probe.instr, prog[m_pc[AW+1:2]]);
        end
        for (int i = 0; i < 32; i++) check($sformatf("rnd_final_x%0d", i), xr(i), mregs[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        logic seen;
        // reset state and basic arithmetic
        clear_rom();
        put(0, enc_i(OPI, 1, 0, 0, 5));
        put(1, enc_i(OPI, 2, 0, 0, -3));
        put(2, enc_r(0, 2, 1, 0, 3));
        start();
        check("reset_pc", probe.addr, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), xr(i), 32'h0);
        repeat (3) step();
        check("add_x1", xr(1), 32'd5);
        check("add_x2", xr(2), 32'hFFFF_FFFD);
        check("add_x3", xr(3), 32'd2);

        // signed vs unsigned compare at the sign boundary
        clear_rom();
        put(0, enc_u(LUI, 5, 32'h8000_0000));
        put(1, enc_i(OPI, 6, 0, 0, -1));
        put(2, enc_r(0, 5, 6, 3, 7));
        put(3, enc_r(0, 5, 6, 2, 8));
        start();
        repeat (4) step();
        check("lui_x5", xr(5), 32'h8000_0000);
        check("sltu_x7", xr(7), 32'd0);
        check("slt_x8", xr(8), 32'd0);

        // taken branch skips one instruction
        clear_rom();
        put(0, enc_i(OPI, 1, 0, 0, 1));
        put(1, enc_b(1, 1, 0, 8));
        put(2, enc_i(OPI, 2, 0, 0, 9));
        put(3, enc_i(OPI, 3, 0, 0, 7));
        start();
        repeat (3) step();
        check("bne_x2", xr(2), 32'd0);
        check("bne_x3", xr(3), 32'd7);
        check("bne_pc", probe.addr, 32'd16);

        // jal and return through jalr
        clear_rom();
        put(0, enc_j(1, 8));
        put(2, enc_i(JALR, 0, 0, 1, 0));
        start();
        repeat (2) step();
        check("jal_x1", xr(1), 32'd4);
        check("jalr_pc", probe.addr, 32'd4);

        // jalr with rd == rs1 uses the old rs1
        clear_rom();
        put(0, enc_i(OPI, 1, 0, 0, 16));
        put(1, enc_i(JALR, 1, 0, 1, 0));
        start();
        repeat (2) step();
        check("jalr_same_pc", probe.addr, 32'd16);
        check("jalr_same_x1", xr(1), 32'd8);

        // x0 stays zero; asynchronous reset mid-program
        clear_rom();
        put(0, enc_i(OPI, 0, 0, 0, 5));
        put(1, enc_r(0, 0, 0, 0, 4));
        put(2, enc_i(OPI, 9, 0, 0, 1));
        put(3, enc_i(OPI, 10, 0, 0, 2));
        start();
        repeat (2) step();
        check("x0_zero", xr(0), 32'd0);
        check("x4_zero", xr(4), 32'd0);
        repeat (2) step();
        check("pre_rst_x9", xr(9), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pc", probe.addr, 32'd0);
        for (int i = 0; i < 32; i++) check($sformatf("async_rst_x%0d", i), xr(i), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_pc", probe.addr, 32'd4);
        check("post_rst_x9", xr(9), 32'd0);

        // small self-test program reporting through x26/x27
        clear_rom();
        put(0, enc_i(OPI, 3, 0, 0, 1));
        put(1, enc_i(OPI, 1, 0, 0, 13));
        put(2, enc_i(OPI, 2, 0, 0, 29));
        put(3, enc_r(0, 2, 1, 0, 4));
        put(4, enc_i(OPI, 5, 0, 0, 42));
        put(5, enc_b(1, 4, 5, 16));
        put(6, enc_i(OPI, 3, 0, 0, 2));
        put(7, enc_i(OPI, 27, 0, 0, 1));
        put(8, enc_j(0, 8));
        put(9, enc_i(OPI, 27, 0, 0, 2));
        put(10, enc_i(OPI, 26, 0, 0, 1));
        put(11, enc_j(0, 0));
        start();
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (xr(26) == 32'd1) begin
                seen = 1'b1;
                check("selftest_pass", xr(27), 32'd1);
            end
        end
        check("selftest_done", {31'b0, seen}, 32'd1);

        // random programs against the model
        for (int p = 0; p < 4; p++) run_random(150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/soc.md
SOC -- requirements
Module: soc

Interface
REQ-001 Parameter ROM_DEPTH, default 4096, instruction ROM size in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low; asserting it acts immediately, independent of clk.
REQ-005 The soc SHALL have no other ports; test status is read hierarchically from the register file.

Function
REQ-006 The soc SHALL implement a single-cycle RV32I core that retires exactly one instruction per clk edge while rst is high.
REQ-007 Fetch SHALL be combinational: instruction = rom_mem[pc[log2(ROM_DEPTH)+1:2]]; pc[1:0] is ignored; the index wraps modulo ROM_DEPTH.
REQ-008 The ROM SHALL contain no initial contents in RTL; it is loaded externally with $readmemh into rom_mem (32-bit words, one per line).
REQ-009 Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
REQ-010 Arithmetic SHALL be 32-bit modulo 2^32; immediates sign-extended per RV32I; shift amount = low 5 bits; SLT signed, SLTU unsigned.
REQ-011 Next PC: pc+4 by default; branch taken -> pc+B-imm; JAL -> pc+J-imm; JALR -> (rs1+I-imm) & ~1; JAL/JALR write pc+4 to rd.
REQ-012 Loads, stores, FENCE, SYSTEM (ECALL/EBREAK/CSR*) and all unrecognised opcodes SHALL execute as NOPs (pc+4, no register write).
REQ-013 Register file: 32 x 32-bit array named regs; two combinational read ports, one write port at rising clk edge.
REQ-014 x0 SHALL read 0 always; writes with rd=0 are discarded.
REQ-015 A JALR with rd==rs1 SHALL use the pre-write rs1 value for the target.
REQ-016 Registers x3 (test number), x26 (done flag) and x27 (pass flag) SHALL have no special hardware behaviour; they are ordinary GPRs observed by the bench.

Reset
REQ-017 While rst is low: pc = RESET_PC and all 32 registers = 0, applied asynchronously.
REQ-018 Reset asserted mid-program SHALL discard the in-flight instruction (no register write); the first instruction after release executes from RESET_PC on the first rising edge with rst high.
REQ-019 ROM contents SHALL be unaffected by reset.

Structure
REQ-020 A shared package SHALL hold opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_REG), funct3/funct7 constants and the ALU-op enum.
REQ-021 Hierarchy SHALL be soc -> riscv_inst (module riscv) and rom_inst (module rom, array rom_mem); riscv -> regs_inst (module regs, array regs); these instance and array names are fixed.
REQ-022 Decode, immediate generation, ALU and next-PC logic SHALL reside in riscv; a separate alu sub-module inside riscv is permitted.

Verification
REQ-023 ROM: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 -> after 3 edges x1=5, x2=32'hFFFF_FFFD, x3=2.
REQ-024 ROM: lui x5,0x80000; addi x6,x0,-1; sltu x7,x6,x5; slt x8,x6,x5 -> x5=32'h8000_0000, x7=0, x8=0.
REQ-025 ROM: addi x1,x0,1; bne x1,x0,+8; addi x2,x0,9; addi x3,x0,7 -> x2=0, x3=7, pc=16 after 3 edges.
REQ-026 ROM: jal x1,+8 at pc 0; jalr x0,0(x1) at pc 8 -> x1=4, pc returns to 4.
REQ-027 addi x0,x0,5 then add x4,x0,x0 -> x0=0, x4=0; pull rst low mid-program -> pc=0 and all regs=0 immediately, without a clk edge.
REQ-028 Load the rv32ui-p-add image -> x26 becomes 1 with x27=1 (pass); no cycle with x26=1 and x27!=1.
